// File: rtl/imem_boot_loader.sv
// Boot loader: turns a little-endian host byte stream into 32-bit instruction words and
// writes them to consecutive instruction-memory addresses, holding the core in reset until done.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   loaded_count
);
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_LEN,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        accept;
    logic        last_byte;
    logic        last_word;
    logic        rearm;
    logic [31:0] word;

    assign accept    = in_valid & in_ready;
    assign last_byte = accept & (byte_cnt_q == 2'd3);
    assign word      = {in_data, asm_q};
    assign last_word = ((count_q + (ADDR_WIDTH+1)'(1)) == len_q);
    assign rearm     = restart & ((state_q == S_DONE) | (state_q == S_ERR));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (last_byte) begin
                    if (word == 32'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, word} > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (last_byte && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (rearm) begin
                    state_d = S_LEN;
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    // done/core_reset wait for the final write pulse to retire before releasing the core
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_LEN, S_LOAD: in_ready = reset;
            S_DONE:        done     = ~we_q;
            S_ERR:         error    = 1'b1;
            default:       in_ready = 1'b0;
        endcase
    end

    assign core_reset   = ~done;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign loaded_count = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            len_q      <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            len_q      <= len_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // The next write address is simply the number of words already written
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        len_d      = len_q;
        count_d    = count_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = in_data;
                2'd1:    asm_d[15:8]  = in_data;
                2'd2:    asm_d[23:16] = in_data;
                default: asm_d        = asm_q;
            endcase
        end

        if (last_byte && (state_q == S_LEN)) begin
            len_d   = word[ADDR_WIDTH:0];
            count_d = '0;
        end

        if (last_byte && (state_q == S_LOAD)) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_WIDTH-1:0];
            wdata_d = word;
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end

        if (rearm) begin
            count_d    = '0;
            byte_cnt_d = 2'd0;
        end
    end

endmodule
